// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO for MULT and DIV.
// Radix-2 Booth multiply and restoring divide, one step per clock over WIDTH cycles.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  state_t                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    div_zero_q;
  logic [WIDTH-1:0]        hi_q;
  logic [WIDTH-1:0]        lo_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    is_div_q;
  logic                    dz_q;

  // Booth state: acc carries a guard bit so subtracting -2^(WIDTH-1) cannot overflow
  logic signed [WIDTH:0]   acc_q;
  logic [WIDTH-1:0]        mq_q;
  logic                    qm1_q;
  logic [WIDTH-1:0]        mcand_q;

  logic [WIDTH-1:0]        rem_q;
  logic [WIDTH-1:0]        quo_q;
  logic [WIDTH-1:0]        dvs_q;
  logic                    neg_quo_q;
  logic                    neg_rem_q;

  logic signed [WIDTH:0]   mcand_ext;
  logic signed [WIDTH:0]   booth_sum;
  logic signed [WIDTH:0]   acc_d;
  logic [WIDTH-1:0]        mq_d;
  logic                    qm1_d;

  logic [WIDTH:0]          rem_shift;
  logic [WIDTH:0]          rem_diff;
  logic                    rem_ge;
  logic [WIDTH-1:0]        rem_d;
  logic [WIDTH-1:0]        quo_d;

  always_comb begin
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_ext;
      2'b10:   booth_sum = acc_q - mcand_ext;
      default: booth_sum = acc_q;
    endcase
    acc_d = booth_sum >>> 1;
    mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
    qm1_d = mq_q[0];
  end

  // Partial remainder stays below the divisor, so the WIDTH+1 bit difference never wraps
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    rem_ge    = ~rem_diff[WIDTH];
    rem_d     = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], rem_ge};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mult_start) begin
            mcand_q  <= a;
            mq_q     <= b;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= MULT;
          end else if (div_start) begin
            is_div_q <= 1'b1;
            busy_q   <= 1'b1;
            if (b == '0) begin
              dz_q    <= 1'b1;
              state_q <= FINISH;
            end else begin
              dz_q      <= 1'b0;
              dvs_q     <= magnitude(b);
              quo_q     <= magnitude(a);
              rem_q     <= '0;
              neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem_q <= a[WIDTH-1];
              cnt_q     <= '0;
              state_q   <= DIV;
            end
          end
        end
        MULT: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_q <= FINISH;
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_q <= FINISH;
        end
        FINISH: begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          // A zero divisor leaves the previous HI/LO visible to MFHI/MFLO
          if (!dz_q) begin
            if (is_div_q) begin
              hi_q <= apply_sign(rem_q, neg_rem_q);
              lo_q <= apply_sign(quo_q, neg_quo_q);
            end else begin
              hi_q <= acc_q[WIDTH-1:0];
              lo_q <= mq_q;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle model built from plain signed arithmetic and a
// completion countdown, checked every cycle, plus directed literal expectations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed with native arithmetic, completion by countdown
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  int          m_left = 0;
  logic        p_dz;
  logic [31:0] p_hi;
  logic [31:0] p_lo;

  task automatic model_step();
    longint      sa, sb;
    logic [63:0] r;
    logic [63:0] q;
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dz   = p_dz;
          if (!p_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (mult_start) begin
        r = sa * sb;
        p_hi = r[63:32]; p_lo = r[31:0]; p_dz = 1'b0;
        m_left = 33; m_busy = 1'b1;
      end else if (div_start) begin
        m_busy = 1'b1;
        if (sb == 0) begin
          p_dz = 1'b1; m_left = 1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          p_lo = q[31:0]; p_hi = r[31:0]; p_dz = 1'b0;
          m_left = 33;
        end
      end
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    chk("cyc_done", {63'd0, done}, {63'd0, m_done});
    chk("cyc_div_zero", {63'd0, div_zero}, {63'd0, m_dz});
    chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
  end

  task automatic wait_done(input string nm, input logic [31:0] eh, input logic [31:0] el,
                           input int ecyc, input logic edz);
    int   bcnt;
    logic got;
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
      chk({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
      chk({nm, "_div_zero"}, {63'd0, div_zero}, {63'd0, edz});
      chk({nm, "_busy_now"}, {63'd0, busy}, 64'd0);
      if (ecyc >= 0) chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(ecyc));
    end
  endtask

  task automatic run_op(input string nm, input logic m, input logic d,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input logic edz, input logic now);
    if (!now) @(negedge clk);
    mult_start = m; div_start = d; a = aa; b = bb;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    a = $urandom(); b = $urandom();
    wait_done(nm, eh, el, ecyc, edz);
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset_n = 1'b1;

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 0, 0);
    run_op("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, 0, 0);
    run_op("mul_max_max", 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 33, 0, 0);
    run_op("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, 0);
    run_op("div_7_m2", 0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 0, 0);
    run_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0, 0);
    run_op("div_m100_m3", 0, 1, 32'hFFFFFF9C, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd33, 33, 0, 0);

    run_op("pre_3x5", 1, 0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 0, 0);
    run_op("div_by_zero", 0, 1, 32'd9, 32'd0, 32'd0, 32'd15, 1, 1, 0);

    // Divide strobe while busy must be dropped, not queued
    run_op("prime_lo", 0, 1, 32'd1000, 32'd7, 32'd6, 32'd142, 33, 0, 0);
    @(negedge clk);
    mult_start = 1'b1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (9) @(negedge clk);
    div_start = 1'b1; a = 32'd100; b = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    wait_done("busy_ignore", 32'd0, 32'd15, -1, 0);
    repeat (40) @(negedge clk);
    chk("busy_ignore_no_queue", {63'd0, busy}, 64'd0);

    run_op("both_strobes", 1, 1, 32'd6, 32'd7, 32'd0, 32'd42, 33, 0, 0);

    // Reset in the middle of a divide abandons it
    @(negedge clk);
    div_start = 1'b1; a = 32'd100; b = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (13) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", {63'd0, seen}, 64'd0);

    // Start coincident with reset is ignored
    reset_n = 1'b0; mult_start = 1'b1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    reset_n = 1'b1; mult_start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {63'd0, busy}, 64'd0);

    run_op("div_100_3", 0, 1, 32'd100, 32'd3, 32'd1, 32'd33, 33, 0, 0);
    run_op("b2b_m1xm1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 33, 0, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
